frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Per-frame sequencer for the game logic and renderer pipeline. Watches the pixel scan coordinates and, once per N video frames during vertical blanking, runs a fixed sequence:
- advance game time;
- trigger the block loader and wait for it;
- let the block position and selector pipeline settle;
- pulse `block_position_ready` to the game state.

This keeps block state from changing mid-frame and gives the game state one well-defined update point per tick.

## Interface
Parameters:
- `V_ACTIVE`, 720: first blanking line; frame end is `y_in == V_ACTIVE && x_in == 0`.
- `FRAMES_PER_TICK`, 1: frames per time advance, range 1..255.
- `PIPE_SETTLE`, 8: cycles to wait after loader completes, range 1..255.
- `LOAD_TIMEOUT`, 1023: maximum cycles spent in LOAD.

Ports:
- `clk_in`  in  1  single system clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `x_in`  in  11  current pixel x.
- `y_in`  in  10  current pixel y.
- `run_in`  in  1  game is in the playing state.
- `pause_in`  in  1  hold time; treated as `run_in` low.
- `load_done_in`  in  1  block loader finished for the new time (level or pulse).
- `clear_err_in`  in  1  clears the sticky error flags.
- `time_tick_out`  out  1  one-cycle pulse; game state increments `curr_time`.
- `load_req_out`  out  1  one-cycle pulse; block loader starts.
- `block_position_ready_out`  out  1  one-cycle pulse to game state.
- `busy_out`  out  1  state is TICK, LOAD, SETTLE or READY.
- `frame_count_out`  out  16  frame-end events seen since reset; wraps.
- `overrun_out`  out  1  sticky: a frame end was dropped while busy.
- `timeout_out`  out  1  sticky: LOAD exited on timeout.

## Operation
Frame-end detection:
- `match` is registered from `x_in == 0 && y_in == V_ACTIVE`.
- `frame_end` is the rising edge of `match`, so exactly one event per frame even if the coordinates stall.
- `frame_count_out` increments on every `frame_end` in every state.

State machine (all outputs registered):
- IDLE: if `run_in && !pause_in`, go to WAIT.
- WAIT:
  - If `!run_in || pause_in`, go to IDLE; the divider is kept.
  - On `frame_end`: if divider == `FRAMES_PER_TICK`-1, clear the divider and go to TICK; otherwise increment the divider.
- TICK: `time_tick_out`=1 for this one cycle; go to LOAD.
- LOAD:
  - `load_req_out`=1 on the first LOAD cycle only; the timeout counter starts at 0.
  - `load_done_in` is accepted on any LOAD cycle, including the first; go to SETTLE.
  - When the counter reaches `LOAD_TIMEOUT`: set `timeout_out` and go to SETTLE.
- SETTLE: wait `PIPE_SETTLE` cycles, then go to READY.
- READY: `block_position_ready_out`=1 for one cycle; go to WAIT if `run_in && !pause_in`, else IDLE.

Boundary rules:
- `frame_end` while busy, including READY: the event is dropped, not queued. Set `overrun_out`; the divider is unchanged.
- `run_in` falls or `pause_in` rises mid-sequence: the sequence runs to READY, then goes to IDLE. A tick is never half-applied.
- `clear_err_in` in the same cycle as a set event: set wins.
- `frame_count_out` wraps 0xFFFF→0.
- Reset asserted mid-operation: immediate return to IDLE, with every output and counter at 0.
- Reset values: state IDLE, every pulse output 0, `busy_out`=0, `frame_count_out`=0, both sticky flags 0, divider 0.

## Timing
- Let edge N sample the matching coordinate. The state is TICK after edge N+1, so `time_tick_out` is high in cycle N+1..N+2.
- `load_req_out` is high after edge N+2.
- With `load_done_in` tied high: SETTLE from edge N+3 and READY after edge N+3+`PIPE_SETTLE`. Minimum tick-to-ready is 2+`PIPE_SETTLE` cycles.
- Loader latency L cycles, measured from the first LOAD cycle to `load_done_in` seen: READY after edge N+3+L+`PIPE_SETTLE`.
- The whole sequence must finish within blanking. Overrun is the only indication that it did not.

## Structure
- Shared package `game_pkg`: the `sched_state_t` enum (IDLE, WAIT, TICK, LOAD, SETTLE, READY) and the video constant `V_ACTIVE_DEFAULT`=720.
- One sub-module, `frame_edge_detect`: coordinate compare plus rising-edge register, producing a one-cycle `frame_end`.
- The FSM and counters live in the top module.

## Test plan
- Reset, then `run_in`=1, `load_done_in`=1, `PIPE_SETTLE`=8, coordinates (0,720) sampled at edge N → `time_tick_out` after N+1, `load_req_out` after N+2, `block_position_ready_out` after N+11; each pulse exactly 1 cycle.
- `FRAMES_PER_TICK`=3, 7 frames → ticks on frames 3 and 6 only; `frame_count_out`=7.
- Hold `load_done_in` low → `timeout_out` set after `LOAD_TIMEOUT` cycles, sequence still reaches READY; `clear_err_in` pulse then clears it.
- Loader latency 2000 cycles with a frame end during LOAD → `overrun_out`=1, no extra tick, next frame ticks normally.
- Drop `run_in` in SETTLE → READY pulse still issued, then IDLE; later frame ends give no ticks, but `frame_count_out` still increments.
- Assert `rst_in` in LOAD, asynchronously mid-cycle → all outputs 0 immediately; `clear_err_in` in the same cycle as an overrun event leaves `overrun_out`=1.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg
// Shared types and constants for the game logic / renderer pipeline.
//   sched_state_t    : frame scheduler state encoding (IDLE is the reset value)
//   V_ACTIVE_DEFAULT : first vertical blanking line for the default video mode
//   sched_is_busy    : true while a tick sequence is in flight
package game_pkg;

  localparam int V_ACTIVE_DEFAULT = 720;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    TICK   = 3'd2,
    LOAD   = 3'd3,
    SETTLE = 3'd4,
    READY  = 3'd5
  } sched_state_t;

  function automatic logic sched_is_busy(input sched_state_t s);
    return (s == TICK) || (s == LOAD) || (s == SETTLE) || (s == READY);
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// frame_edge_detect
// Registers the "first blanking pixel" coordinate match and emits a one-cycle
// frame_end on its rising edge, so a stalled scan position still yields a
// single event per frame.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   x, y      : current pixel coordinates
//   frame_end : one-cycle pulse, high in the cycle after the match is sampled
module frame_edge_detect
  import game_pkg::*;
#(
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  output logic        frame_end
);

  logic match;
  logic match_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match      <= 1'b0;
      match_prev <= 1'b0;
    end else begin
      match      <= (x == 11'd0) && (y == 10'(V_ACTIVE));
      match_prev <= match;
    end
  end

  assign frame_end = match & ~match_prev;

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler
// Once every FRAMES_PER_TICK frames, at the start of vertical blanking, runs
// the update sequence: pulse time_tick_out, request a block load and wait for
// it (bounded by LOAD_TIMEOUT), let the block pipeline settle for PIPE_SETTLE
// cycles, then pulse block_position_ready_out.
// Ports:
//   clk_in, rst_in            : clock, asynchronous active-high reset
//   x_in, y_in                : pixel scan coordinates
//   run_in, pause_in          : sequencing enabled when run_in && !pause_in
//   load_done_in              : loader completion (level or pulse)
//   clear_err_in              : clears overrun_out / timeout_out
//   time_tick_out             : one-cycle pulse, advance game time
//   load_req_out              : one-cycle pulse, start the block loader
//   block_position_ready_out  : one-cycle pulse, block state is consistent
//   busy_out                  : a tick sequence is in flight
//   frame_count_out           : frame-end events since reset (wraps)
//   overrun_out, timeout_out  : sticky error flags
//   state_out                 : current FSM state (debug)
//
// Loader handshake: load_req_out is a single-cycle request issued on the first
// LOAD cycle; load_done_in is sampled on every LOAD cycle including that first
// one, and any high sample completes the load. Outside LOAD it is ignored.
module frame_scheduler
  import game_pkg::*;
#(
  parameter int V_ACTIVE        = V_ACTIVE_DEFAULT,
  parameter int FRAMES_PER_TICK = 1,
  parameter int PIPE_SETTLE     = 8,
  parameter int LOAD_TIMEOUT    = 1023
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [10:0]  x_in,
  input  logic [9:0]   y_in,
  input  logic         run_in,
  input  logic         pause_in,
  input  logic         load_done_in,
  input  logic         clear_err_in,
  output logic         time_tick_out,
  output logic         load_req_out,
  output logic         block_position_ready_out,
  output logic         busy_out,
  output logic [15:0]  frame_count_out,
  output logic         overrun_out,
  output logic         timeout_out,
  output sched_state_t state_out
);

  // One counter serves both LOAD (timeout) and SETTLE, sized for the larger.
  localparam int              CW           = (LOAD_TIMEOUT > 255) ? $clog2(LOAD_TIMEOUT + 1) : 8;
  localparam logic [CW-1:0]   TIMEOUT_LAST = CW'(LOAD_TIMEOUT - 1);
  localparam logic [CW-1:0]   SETTLE_LAST  = CW'(PIPE_SETTLE - 1);
  localparam logic [7:0]      DIV_LAST     = 8'(FRAMES_PER_TICK - 1);

  sched_state_t    state;
  sched_state_t    next_state;
  logic            frame_end;
  logic            go;
  logic [7:0]      div;
  logic [CW-1:0]   cnt;
  logic            div_clr;
  logic            div_inc;
  logic            timeout_set;
  logic            overrun_set;
  logic            tick_d;
  logic            load_req_d;
  logic            ready_d;
  logic            busy_d;

  frame_edge_detect #(
    .V_ACTIVE (V_ACTIVE)
  ) u_edge (
    .clk       (clk_in),
    .rst       (rst_in),
    .x         (x_in),
    .y         (y_in),
    .frame_end (frame_end)
  );

  assign go          = run_in && !pause_in;
  // A frame end arriving mid-sequence is dropped, never queued.
  assign overrun_set = frame_end && sched_is_busy(state);
  assign state_out   = state;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state  = state;
    div_clr     = 1'b0;
    div_inc     = 1'b0;
    timeout_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) next_state = WAIT;
      end
      WAIT: begin
        if (!go) begin
          next_state = IDLE;
        end else if (frame_end) begin
          if (div == DIV_LAST) begin
            div_clr    = 1'b1;
            next_state = TICK;
          end else begin
            div_inc = 1'b1;
          end
        end
      end
      TICK: begin
        next_state = LOAD;
      end
      LOAD: begin
        if (load_done_in) begin
          next_state = SETTLE;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_set = 1'b1;
          next_state  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) next_state = READY;
      end
      READY: begin
        // run/pause changes mid-sequence only take effect here.
        next_state = go ? WAIT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode, registered below so every output comes straight from a flop.
  always_comb begin
    tick_d     = (next_state == TICK);
    load_req_d = (next_state == LOAD) && (state != LOAD);
    ready_d    = (next_state == READY);
    busy_d     = sched_is_busy(next_state);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      time_tick_out            <= 1'b0;
      load_req_out             <= 1'b0;
      block_position_ready_out <= 1'b0;
      busy_out                 <= 1'b0;
    end else begin
      time_tick_out            <= tick_d;
      load_req_out             <= load_req_d;
      block_position_ready_out <= ready_d;
      busy_out                 <= busy_d;
    end
  end

  // Cycle counter: restarts on every state change, counts in LOAD and SETTLE.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (state != next_state) begin
      cnt <= '0;
    end else if ((state == LOAD) || (state == SETTLE)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Frame divider survives IDLE so pausing does not lose partial progress.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)       div <= 8'd0;
    else if (div_clr) div <= 8'd0;
    else if (div_inc) div <= div + 8'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)         frame_count_out <= 16'd0;
    else if (frame_end) frame_count_out <= frame_count_out + 16'd1;
  end

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun_out <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      if (overrun_set)       overrun_out <= 1'b1;
      else if (clear_err_in) overrun_out <= 1'b0;
      if (timeout_set)       timeout_out <= 1'b1;
      else if (clear_err_in) timeout_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler
// Directed bench for frame_scheduler. Pulse outputs are checked by a monitor
// against an expected queue of {kind, cycle} entries pushed by the drivers;
// flags and counters are checked directly by the main sequence.
module tb_frame_scheduler;
  import game_pkg::*;

  localparam int VA = 720;
  localparam int PS = 8;
  localparam int LT = 3000;

  localparam logic [1:0] K_TICK = 2'd0;
  localparam logic [1:0] K_LREQ = 2'd1;
  localparam logic [1:0] K_RDY  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- DUT signals ----------------
  logic [10:0] x;
  logic [9:0]  y;
  logic        run, pause, load_done, clear_err;

  logic         tick, lreq, rdy, busy, ovr, tmo;
  logic [15:0]  fc;
  sched_state_t st;

  logic         tick3, lreq3, rdy3, busy3, ovr3, tmo3;
  logic [15:0]  fc3;
  sched_state_t st3;

  frame_scheduler #(
    .V_ACTIVE(VA), .FRAMES_PER_TICK(1), .PIPE_SETTLE(PS), .LOAD_TIMEOUT(LT)
  ) dut (
    .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .run_in(run),
    .pause_in(pause), .load_done_in(load_done), .clear_err_in(clear_err),
    .time_tick_out(tick), .load_req_out(lreq), .block_position_ready_out(rdy),
    .busy_out(busy), .frame_count_out(fc), .overrun_out(ovr),
    .timeout_out(tmo), .state_out(st)
  );

  frame_scheduler #(
    .V_ACTIVE(VA), .FRAMES_PER_TICK(3), .PIPE_SETTLE(PS)
  ) dut3 (
    .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .run_in(run),
    .pause_in(pause), .load_done_in(load_done), .clear_err_in(clear_err),
    .time_tick_out(tick3), .load_req_out(lreq3), .block_position_ready_out(rdy3),
    .busy_out(busy3), .frame_count_out(fc3), .overrun_out(ovr3),
    .timeout_out(tmo3), .state_out(st3)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [31:0] exp3_q[$];
  int   passed = 0;
  int   total  = 0;
  int   exp_fc = 0;
  logic phase3 = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic push(input logic [1:0] k, input int c);
    exp_q.push_back({k, 32'(c)});
  endtask

  task automatic check_pop(input logic [1:0] k, input string nm);
    logic [33:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: unexpected pulse at cycle %0d, none expected", nm, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e == {k, cyc}) passed++;
      else $display("FAIL %s: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                    nm, k, cyc, e[33:32], e[31:0]);
    end
  endtask

  task automatic check_pop3();
    logic [31:0] e;
    total++;
    if (exp3_q.size() == 0) begin
      $display("FAIL tick3: unexpected tick at cycle %0d, none expected", cyc);
    end else begin
      e = exp3_q.pop_front();
      if (e == cyc) passed++;
      else $display("FAIL tick3: got tick at cycle %0d, expected cycle %0d", cyc, e);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (tick) check_pop(K_TICK, "time_tick");
      if (lreq) check_pop(K_LREQ, "load_req");
      if (rdy)  check_pop(K_RDY,  "block_ready");
      if (phase3 && tick3) check_pop3();
    end
  end

  // ---------------- driver tasks ----------------
  // Presents the frame-end coordinate for exactly one sampling edge (edge N)
  // and returns on the falling edge after it with n = N.
  task automatic do_frame(output int n);
    @(negedge clk);
    x = 11'd0;
    y = 10'(VA);
    @(negedge clk);
    n = int'(cyc);
    x = 11'd37;
    y = 10'd3;
    exp_fc++;
  endtask

  // Full sequence with the loader answering on LOAD cycle index l.
  task automatic push_seq(input int n, input int l);
    push(K_TICK, n + 1);
    push(K_LREQ, n + 2);
    push(K_RDY,  n + 3 + l + PS);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_until(input int c);
    while (int'(cyc) < c) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int m;
    x = 11'd100; y = 10'd0;
    run = 1'b0; pause = 1'b0; load_done = 1'b0; clear_err = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state",   32'(st),   32'(IDLE));
    check("rst_tick",    32'(tick), 32'd0);
    check("rst_lreq",    32'(lreq), 32'd0);
    check("rst_ready",   32'(rdy),  32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_fc",      32'(fc),   32'd0);
    check("rst_overrun", 32'(ovr),  32'd0);
    check("rst_timeout", 32'(tmo),  32'd0);

    // Basic timing plus divide-by-3 on the second instance.
    run = 1'b1; load_done = 1'b1; phase3 = 1'b1;
    repeat (2) @(negedge clk);
    for (int f = 1; f <= 7; f++) begin
      do_frame(n);
      push_seq(n, 0);
      if (f % 3 == 0) exp3_q.push_back(32'(n + 1));
      repeat (20) @(negedge clk);
    end
    wait_drain(50);
    check("div3_ticks_left", 32'(exp3_q.size()), 32'd0);
    phase3 = 1'b0;
    check("fc_after_7", 32'(fc),  32'(exp_fc));
    check("fc3_after_7", 32'(fc3), 32'd7);
    check("no_overrun", 32'(ovr), 32'd0);

    // Loader never answers: timeout after LT cycles in LOAD.
    load_done = 1'b0;
    do_frame(n);
    push(K_TICK, n + 1);
    push(K_LREQ, n + 2);
    push(K_RDY,  n + 2 + LT + PS);
    wait_until(n + 1 + LT);
    check("timeout_before", 32'(tmo), 32'd0);
    @(negedge clk);
    check("timeout_set", 32'(tmo), 32'd1);
    wait_drain(100);
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    check("timeout_cleared", 32'(tmo), 32'd0);

    // Slow loader (2000 cycles) with a frame end arriving during LOAD.
    do_frame(n);
    push_seq(n, 2000);
    repeat (100) @(negedge clk);
    check("overrun_before", 32'(ovr), 32'd0);
    do_frame(m);
    @(negedge clk);
    check("overrun_set", 32'(ovr),  32'd1);
    check("busy_in_load", 32'(busy), 32'd1);
    check("fc_overrun", 32'(fc), 32'(exp_fc));
    wait_until(n + 2 + 2000);
    load_done = 1'b1;
    wait_drain(50);
    repeat (5) @(negedge clk);
    do_frame(n);
    push_seq(n, 0);
    wait_drain(50);

    // run drops during SETTLE: READY still issued, then IDLE.
    do_frame(n);
    push_seq(n, 0);
    wait_until(n + 6);
    run = 1'b0;
    wait_drain(50);
    repeat (2) @(negedge clk);
    check("idle_after_ready", 32'(st),   32'(IDLE));
    check("not_busy_idle",    32'(busy), 32'd0);
    for (int f = 0; f < 2; f++) begin
      do_frame(m);
      repeat (20) @(negedge clk);
    end
    check("fc_while_idle", 32'(fc), 32'(exp_fc));

    // Clear alone, then clear coinciding with an overrun event.
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    check("overrun_cleared", 32'(ovr), 32'd0);
    run = 1'b1; load_done = 1'b0;
    repeat (3) @(negedge clk);
    do_frame(n);
    push(K_TICK, n + 1);
    push(K_LREQ, n + 2);
    wait_drain(20);
    repeat (4) @(negedge clk);
    do_frame(m);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("set_beats_clear", 32'(ovr), 32'd1);
    check("fc_before_rst", 32'(fc), 32'(exp_fc));
    check("state_load", 32'(st), 32'(LOAD));

    // Asynchronous reset in the middle of a clock phase while in LOAD.
    #2 rst = 1'b1;
    #1;
    check("arst_state",   32'(st),   32'(IDLE));
    check("arst_tick",    32'(tick), 32'd0);
    check("arst_lreq",    32'(lreq), 32'd0);
    check("arst_ready",   32'(rdy),  32'd0);
    check("arst_busy",    32'(busy), 32'd0);
    check("arst_fc",      32'(fc),   32'd0);
    check("arst_fc3",     32'(fc3),  32'd0);
    check("arst_overrun", 32'(ovr),  32'd0);
    check("arst_timeout", 32'(tmo),  32'd0);
    repeat (3) @(negedge clk);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
